// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write architectural register file.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  // One byte lane of a byte-enabled merge; wider words are built lane by lane.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    logic [7:0] res;
    if (be) begin
      res = new_byte;
    end else begin
      res = old_byte;
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_byte_merge.sv
// Combinational byte-enabled merge of a new word over an old word.
module rf_byte_merge
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  for (genvar k = 0; k < DATA_W / 8; k++) begin : g_lane
    assign merged[8*k +: 8] = byte_merge(old_word[8*k +: 8], new_word[8*k +: 8], be[k]);
  end

endmodule

// File: rtl/regfile_2r1w.sv
// DEPTH x DATA_W register file: two registered read ports, one byte-enabled
// write port, optional hardwired r0, optional write forwarding and a swept clear.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                i_CLK,
  input  logic                i_ASRST,
  input  logic                i_CLR,
  input  logic                i_WE,
  input  logic [ADDR_W-1:0]   i_WADDR,
  input  logic [DATA_W-1:0]   i_WD,
  input  logic [DATA_W/8-1:0] i_WBE,
  input  logic [ADDR_W-1:0]   i_RADDR_A,
  input  logic [ADDR_W-1:0]   i_RADDR_B,
  output logic [DATA_W-1:0]   o_RD_A,
  output logic [DATA_W-1:0]   o_RD_B,
  output logic                o_BUSY
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  rf_state_e         state_r;
  rf_state_e         state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic              busy_r;
  logic [DATA_W-1:0] rd_a_r;
  logic [DATA_W-1:0] rd_b_r;

  logic              wr_en_s;
  logic [DATA_W-1:0] wr_merged_s;
  logic [DATA_W-1:0] byp_a_s;
  logic [DATA_W-1:0] byp_b_s;
  logic [DATA_W-1:0] rd_a_nxt_s;
  logic [DATA_W-1:0] rd_b_nxt_s;

  rf_byte_merge #(.DATA_W(DATA_W)) u_merge_wr (
    .old_word (mem_r[i_WADDR]),
    .new_word (i_WD),
    .be       (i_WBE),
    .merged   (wr_merged_s)
  );

  rf_byte_merge #(.DATA_W(DATA_W)) u_merge_a (
    .old_word (mem_r[i_RADDR_A]),
    .new_word (i_WD),
    .be       (i_WBE),
    .merged   (byp_a_s)
  );

  rf_byte_merge #(.DATA_W(DATA_W)) u_merge_b (
    .old_word (mem_r[i_RADDR_B]),
    .new_word (i_WD),
    .be       (i_WBE),
    .merged   (byp_b_s)
  );

  // Write qualification: writes only land in IDLE, and never on a hardwired r0.
  always_comb begin
    wr_en_s = 1'b0;
    if (state_r == ST_IDLE && i_WE) begin
      if (ZERO_REG && i_WADDR == {ADDR_W{1'b0}}) begin
        wr_en_s = 1'b0;
      end else begin
        wr_en_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Port A read selection: hardwired zero, word being cleared, forwarded write, stored word.
  always_comb begin
    rd_a_nxt_s = mem_r[i_RADDR_A];
    if (ZERO_REG && i_RADDR_A == {ADDR_W{1'b0}}) begin
      rd_a_nxt_s = {DATA_W{1'b0}};
    end else if (state_r == ST_CLEAR && i_RADDR_A == cnt_r) begin
      rd_a_nxt_s = {DATA_W{1'b0}};
    end else if (BYPASS && wr_en_s && i_WADDR == i_RADDR_A) begin
      rd_a_nxt_s = byp_a_s;
    end else begin
      rd_a_nxt_s = mem_r[i_RADDR_A];
    end
  end

  // Port B read selection, same priority as port A.
  always_comb begin
    rd_b_nxt_s = mem_r[i_RADDR_B];
    if (ZERO_REG && i_RADDR_B == {ADDR_W{1'b0}}) begin
      rd_b_nxt_s = {DATA_W{1'b0}};
    end else if (state_r == ST_CLEAR && i_RADDR_B == cnt_r) begin
      rd_b_nxt_s = {DATA_W{1'b0}};
    end else if (BYPASS && wr_en_s && i_WADDR == i_RADDR_B) begin
      rd_b_nxt_s = byp_b_s;
    end else begin
      rd_b_nxt_s = mem_r[i_RADDR_B];
    end
  end

  // Clear sweep sequencing.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_CLR) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == {ADDR_W{1'b1}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state, sweep counter and registered read/busy outputs.
  always_ff @(posedge i_CLK or posedge i_ASRST) begin
    if (i_ASRST) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      rd_a_r  <= {DATA_W{1'b0}};
      rd_b_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
      rd_a_r  <= rd_a_nxt_s;
      rd_b_r  <= rd_b_nxt_s;
      if (state_r == ST_CLEAR) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Storage: flop array so the asynchronous reset clears every word.
  always_ff @(posedge i_CLK or posedge i_ASRST) begin
    if (i_ASRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[cnt_r] <= {DATA_W{1'b0}};
    end else if (wr_en_s) begin
      mem_r[i_WADDR] <= wr_merged_s;
    end
  end

  assign o_RD_A = rd_a_r;
  assign o_RD_B = rd_b_r;
  assign o_BUSY = busy_r;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: one instance with hardwired r0 + forwarding, one without,
// both checked against an array-based model of the architectural behaviour.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic        busy1, busy0;

  int errors = 0;
  int checks = 0;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut1 (
    .i_CLK(clk), .i_ASRST(rst), .i_CLR(clr), .i_WE(we), .i_WADDR(waddr), .i_WD(wd),
    .i_WBE(wbe), .i_RADDR_A(raddr_a), .i_RADDR_B(raddr_b),
    .o_RD_A(rd_a1), .o_RD_B(rd_b1), .o_BUSY(busy1)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut0 (
    .i_CLK(clk), .i_ASRST(rst), .i_CLR(clr), .i_WE(we), .i_WADDR(waddr), .i_WD(wd),
    .i_WBE(wbe), .i_RADDR_A(raddr_a), .i_RADDR_B(raddr_b),
    .o_RD_A(rd_a0), .o_RD_B(rd_b0), .o_BUSY(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m1 for the r0/forwarding instance, m0 for the plain one.
  logic [31:0] m1 [32];
  logic [31:0] m0 [32];
  bit          sweeping;
  int          sweep_idx;
  logic [31:0] e_a1, e_b1, e_a0, e_b0;
  bit          e_busy;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m1[i] = 32'h0;
      m0[i] = 32'h0;
    end
    sweeping = 1'b0; sweep_idx = 0;
    e_a1 = 32'h0; e_b1 = 32'h0; e_a0 = 32'h0; e_b0 = 32'h0; e_busy = 1'b0;
  endtask

  // Predict outputs for the coming edge from the current inputs, then advance one clock.
  task automatic tick();
    bit w1, w0;
    logic [31:0] post1, post0;
    w1 = !sweeping && we && (waddr != 5'd0);
    w0 = !sweeping && we;
    post1 = merge(m1[waddr], wd, wbe);
    post0 = merge(m0[waddr], wd, wbe);
    if (raddr_a == 5'd0) e_a1 = 32'h0;
    else if (sweeping && raddr_a == sweep_idx[4:0]) e_a1 = 32'h0;
    else if (w1 && waddr == raddr_a) e_a1 = post1;
    else e_a1 = m1[raddr_a];
    if (raddr_b == 5'd0) e_b1 = 32'h0;
    else if (sweeping && raddr_b == sweep_idx[4:0]) e_b1 = 32'h0;
    else if (w1 && waddr == raddr_b) e_b1 = post1;
    else e_b1 = m1[raddr_b];
    e_a0 = (sweeping && raddr_a == sweep_idx[4:0]) ? 32'h0 : m0[raddr_a];
    e_b0 = (sweeping && raddr_b == sweep_idx[4:0]) ? 32'h0 : m0[raddr_b];
    if (sweeping) begin
      m1[sweep_idx] = 32'h0;
      m0[sweep_idx] = 32'h0;
      if (sweep_idx == 31) sweeping = 1'b0;
      sweep_idx = (sweep_idx + 1) % 32;
    end else begin
      if (w1) m1[waddr] = post1;
      if (w0) m0[waddr] = post0;
      if (clr) sweeping = 1'b1;
    end
    e_busy = sweeping;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 1'b0; we = 1'b0; waddr = 5'd0; wd = 32'h0; wbe = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs(); raddr_a = 5'd0; raddr_b = 5'd0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({rd_a1, rd_b1, rd_a0, rd_b0} !== 128'h0 || busy1 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got a1=%h b1=%h a0=%h b0=%h busy=%b%b, want all 0",
               rd_a1, rd_b1, rd_a0, rd_b0, busy1, busy0);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    we = 1'b1; waddr = 5'd5; wd = 32'hDEADBEEF; wbe = 4'hF;
    tick();
    idle_inputs(); raddr_a = 5'd5; raddr_b = 5'd5;
    tick();
    checks++;
    if (rd_a1 !== 32'hDEADBEEF || rd_b0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fill_r5: got a1=%h b0=%h want DEADBEEF", rd_a1, rd_b0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rd_a1, rd_b1, rd_a0, rd_b0} !== 128'h0 || busy1 !== 1'b0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got a1=%h b1=%h a0=%h b0=%h busy=%b%b, want all 0",
               rd_a1, rd_b1, rd_a0, rd_b0, busy1, busy0);
    end
    model_reset();
    #2 rst = 1'b0;
    tick();
    checks++;
    if (rd_a1 !== 32'h0 || rd_a0 !== 32'h0) begin
      errors++;
      $display("FAIL r5_after_reset: got a1=%h a0=%h want 0", rd_a1, rd_a0);
    end
  endtask

  task automatic test_byte_enable();
    we = 1'b1; waddr = 5'd3; wd = 32'h11223344; wbe = 4'hF;
    tick();
    wd = 32'hAABBCCDD; wbe = 4'b0101;
    tick();
    idle_inputs(); raddr_a = 5'd3; raddr_b = 5'd3;
    tick();
    checks++;
    if (rd_a1 !== 32'h11BB33DD || rd_b1 !== 32'h11BB33DD || rd_a0 !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_enable: got a1=%h b1=%h a0=%h want 11BB33DD", rd_a1, rd_b1, rd_a0);
    end
    we = 1'b1; waddr = 5'd3; wd = 32'hFFFFFFFF; wbe = 4'h0;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (rd_a1 !== 32'h11BB33DD || rd_b0 !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL wbe_zero_noop: got a1=%h b0=%h want 11BB33DD", rd_a1, rd_b0);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wd = 32'hFFFFFFFF; wbe = 4'hF;
    tick();
    idle_inputs(); raddr_a = 5'd0; raddr_b = 5'd0;
    tick();
    checks++;
    if (rd_a1 !== 32'h0 || rd_b1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_on: got a=%h b=%h want 0", rd_a1, rd_b1);
    end
    checks++;
    if (rd_a0 !== 32'hFFFFFFFF || rd_b0 !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL zero_reg_off: got a=%h b=%h want FFFFFFFF", rd_a0, rd_b0);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wd = 32'hCAFE0000; wbe = 4'hF;
    tick();
    wd = 32'h00000055; wbe = 4'b0001; raddr_a = 5'd7; raddr_b = 5'd7;
    tick();
    checks++;
    if (rd_a1 !== 32'hCAFE0055 || rd_b1 !== 32'hCAFE0055) begin
      errors++;
      $display("FAIL bypass_on: got a=%h b=%h want CAFE0055", rd_a1, rd_b1);
    end
    checks++;
    if (rd_a0 !== 32'hCAFE0000) begin
      errors++;
      $display("FAIL bypass_off: got %h want CAFE0000", rd_a0);
    end
    idle_inputs();
    tick();
    checks++;
    if (rd_a0 !== 32'hCAFE0055) begin
      errors++;
      $display("FAIL post_write: got %h want CAFE0055", rd_a0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      clr = 1'b0;
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      wd = $urandom;
      wbe = 4'($urandom);
      raddr_a = 5'($urandom_range(0, 7));
      raddr_b = 5'($urandom_range(0, 7));
      tick();
      checks++;
      if (rd_a1 !== e_a1 || rd_b1 !== e_b1 || rd_a0 !== e_a0 || rd_b0 !== e_b0 || busy1 !== e_busy) begin
        errors++;
        $display("FAIL random[%0d]: got %h %h %h %h busy=%b want %h %h %h %h busy=%b", n,
                 rd_a1, rd_b1, rd_a0, rd_b0, busy1, e_a1, e_b1, e_a0, e_b0, e_busy);
      end
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wd = $urandom | 32'h1; wbe = 4'hF;
      tick();
    end
    idle_inputs(); clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 100 && busy1 === 1'b1; c++) begin
      busy_cycles++;
      clr = 1'($urandom_range(0, 1));
      we = 1'b1; waddr = 5'($urandom); wd = $urandom | 32'h1; wbe = 4'hF;
      raddr_a = 5'($urandom); raddr_b = 5'($urandom);
      tick();
      checks++;
      if (rd_a1 !== e_a1 || rd_b1 !== e_b1 || rd_a0 !== e_a0 || rd_b0 !== e_b0 ||
          busy1 !== e_busy || busy0 !== e_busy) begin
        errors++;
        $display("FAIL sweep[%0d]: got %h %h %h %h busy=%b%b want %h %h %h %h busy=%b", c,
                 rd_a1, rd_b1, rd_a0, rd_b0, busy1, busy0, e_a1, e_b1, e_a0, e_b0, e_busy);
      end
    end
    idle_inputs();
    checks++;
    if (busy_cycles != 32 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL busy_length: got %0d cycles (busy now %b) want 32", busy_cycles, busy1);
    end
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      tick();
      checks++;
      if (rd_a1 !== 32'h0 || rd_b1 !== 32'h0 || rd_a0 !== 32'h0 || rd_b0 !== 32'h0) begin
        errors++;
        $display("FAIL cleared[%0d]: got %h %h %h %h want 0", i, rd_a1, rd_b1, rd_a0, rd_b0);
      end
    end
  endtask

  task automatic test_clr_with_we();
    we = 1'b1; waddr = 5'd4; wd = 32'h00000077; wbe = 4'hF; clr = 1'b1; raddr_a = 5'd4;
    tick();
    idle_inputs();
    checks++;
    if (busy1 !== 1'b1 || rd_a1 !== 32'h00000077 || rd_a0 !== 32'h0) begin
      errors++;
      $display("FAIL clr_and_we: got busy=%b a1=%h a0=%h want 1 00000077 0", busy1, rd_a1, rd_a0);
    end
    for (int c = 0; c < 40 && busy1 === 1'b1; c++) tick();
    raddr_a = 5'd4; raddr_b = 5'd4;
    tick();
    checks++;
    if (busy1 !== 1'b0 || rd_a1 !== 32'h0 || rd_b0 !== 32'h0) begin
      errors++;
      $display("FAIL clr_we_zeroed: got busy=%b a1=%h b0=%h want 0", busy1, rd_a1, rd_b0);
    end
  endtask

  task automatic test_clear_reset();
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wd = $urandom | 32'h1; wbe = 4'hF;
      tick();
    end
    idle_inputs(); clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (busy1 !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_running: got busy=%b%b want 11", busy1, busy0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy1 !== 1'b0 || busy0 !== 1'b0 || {rd_a1, rd_b1, rd_a0, rd_b0} !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid_sweep: got busy=%b%b a1=%h b1=%h a0=%h b0=%h want 0",
               busy1, busy0, rd_a1, rd_b1, rd_a0, rd_b0);
    end
    model_reset();
    #2 rst = 1'b0;
    we = 1'b1; waddr = 5'd9; wd = 32'h12345678; wbe = 4'hF; raddr_a = 5'd9; raddr_b = 5'd20;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (rd_a1 !== 32'h12345678 || rd_a0 !== 32'h12345678 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL write_after_reset: got a1=%h a0=%h busy=%b want 12345678 busy=0",
               rd_a1, rd_a0, busy1);
    end
    checks++;
    if (rd_b1 !== 32'h0 || rd_b0 !== 32'h0) begin
      errors++;
      $display("FAIL unswept_zero: got b1=%h b0=%h want 0", rd_b1, rd_b0);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_byte_enable();
    test_zero_reg();
    test_bypass();
    test_random();
    test_clear();
    test_clr_with_we();
    test_clear_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
